// File: rtl/multiplier_pkg.sv
// Shared types and width helpers for the pipelined multiplier.
package multiplier_pkg;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_mode_t;

  function automatic int prod_width(input int width, input int full);
    return (full != 0) ? 2 * width : width;
  endfunction

  function automatic int occ_width(input int latency);
    return $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/multiplier_pipe_stage.sv
// One pipeline register holding {valid, data}; advances on en, valid cleared by clr.
module multiplier_pipe_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  // clr wins over en so a flush empties the stage even while the pipe advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clr)
        valid <= 1'b0;
      else if (en)
        valid <= load_valid;
      if (en)
        data <= load_data;
    end
  end

endmodule

// File: rtl/multiplier_pipe.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready handshake, freeze stall and flush.
module multiplier_pipe
  import multiplier_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int LATENCY      = 8,
  parameter int FULL_PRODUCT = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [WIDTH-1:0]                             in_a,
  input  logic [WIDTH-1:0]                             in_b,
  input  logic                                         in_signed,
  input  logic                                         flush,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [prod_width(WIDTH, FULL_PRODUCT)-1:0]   out_product,
  output logic [occ_width(LATENCY)-1:0]                occupancy,
  output logic                                         busy
);

  localparam int PW = prod_width(WIDTH, FULL_PRODUCT);
  localparam int OW = occ_width(LATENCY);

  mul_mode_t            mode;
  logic                 ext_a_bit;
  logic                 ext_b_bit;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   prod_full;
  logic                 adv;
  logic                 accept;
  logic                 emit;

  logic [LATENCY:0]     valid_chain;
  logic [PW-1:0]        data_chain [LATENCY+1];

  assign mode      = in_signed ? MUL_SIGNED : MUL_UNSIGNED;
  assign ext_a_bit = (mode == MUL_SIGNED) & in_a[WIDTH-1];
  assign ext_b_bit = (mode == MUL_SIGNED) & in_b[WIDTH-1];
  assign ext_a     = {{WIDTH{ext_a_bit}}, in_a};
  assign ext_b     = {{WIDTH{ext_b_bit}}, in_b};
  assign prod_full = ext_a * ext_b;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !flush;
  assign accept   = in_valid && in_ready;
  assign emit     = out_valid && out_ready;

  assign valid_chain[0] = accept;
  assign data_chain[0]  = prod_full[PW-1:0];

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    multiplier_pipe_stage #(
      .DW (PW)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (adv),
      .clr        (flush),
      .load_valid (valid_chain[g]),
      .load_data  (data_chain[g]),
      .valid      (valid_chain[g+1]),
      .data       (data_chain[g+1])
    );
  end

  assign out_valid   = valid_chain[LATENCY];
  assign out_product = data_chain[LATENCY];

  // Counter mirrors the number of set valid bits; simultaneous in/out cancels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      case ({accept, emit})
        2'b10:   occupancy <= occupancy + OW'(1);
        2'b01:   occupancy <= occupancy - OW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign busy = (occupancy != '0);

endmodule
